// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder family.
//   state_e   : controller states
//   ndig_of   : number of digit cycles per operation
//   cnt_w     : digit-index width (never below 1 bit)
//   width_ok  : legality check, WIDTH must be a non-zero multiple of DIGIT
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ndig_of(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  function automatic bit width_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice.
//   a, b : digit operands
//   cin  : carry into bit 0
//   s    : digit sum
//   cout : carry out of the top bit
module adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/adder_serial_nbit.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, LSB first.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, taken only in IDLE or DONE
//   a, b, cin, sub  : operands / carry-in / subtract select, latched on accept
//   busy            : digits in flight
//   done            : one-cycle pulse when sum/cout/ovf update
//   sum, cout, ovf  : result, carry out (sub: 1 = no borrow), signed overflow
module adder_serial_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig_of(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] K_LAST = CW'(NDIG - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("adder_serial_nbit: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // holds B' (already inverted for subtract)
  logic             carry_q, carry_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] full;

  assign dig_a = a_q[int'(k_q)*DIGIT +: DIGIT];
  assign dig_b = b_q[int'(k_q)*DIGIT +: DIGIT];

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    full    = psum_q;
    full[int'(k_q)*DIGIT +: DIGIT] = dig_s;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          // Subtract is a + ~b + 1 - borrow_in, so the initial carry is ~cin.
          carry_d = cin ^ sub;
          k_d     = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        psum_d  = full;
        carry_d = dig_c;
        if (k_q == K_LAST) begin
          state_d = DONE;
          sum_d   = full;
          cout_d  = dig_c;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);
          k_d     = '0;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Directed bench: 16-bit/4-bit-digit instance plus a 4/4 legacy instance.
module tb_adder_serial_nbit;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cin, sub, busy, done, cout, ovf;
  logic [15:0] a, b, sum;

  logic        lstart, lcin, lsub, lbusy, ldone, lcout, lovf;
  logic [3:0]  la, lb, lsum;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  adder_serial_nbit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_serial_nbit #(.WIDTH(4), .DIGIT(4)) dut_l (
    .clk(clk), .rst(rst), .start(lstart), .a(la), .b(lb), .cin(lcin), .sub(lsub),
    .busy(lbusy), .done(ldone), .sum(lsum), .cout(lcout), .ovf(lovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic s);
    logic [15:0] bp;
    logic [16:0] r;
    exp_t e;
    bp = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, bp} + {16'd0, c ^ s};
    e.s = r[15:0];
    e.c = r[16];
    e.o = (x[15] == bp[15]) && (r[15] != x[15]);
    return e;
  endfunction

  // Advance on falling edges until done or budget runs out; n counts edges since accept.
  task automatic wait_done(inout int n);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, " sum"},  {16'd0, sum}, {16'd0, e.s});
      chk({tag, " cout"}, {31'd0, cout}, {31'd0, e.c});
      chk({tag, " ovf"},  {31'd0, ovf},  {31'd0, e.o});
    end
  endtask

  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic ts, input exp_t e);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    chk({tag, " latency"}, n, 32'd4);
    pop_cmp(tag);
  endtask

  task automatic op4(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                     input logic tc, input logic [3:0] es, input logic ec);
    int n;
    @(negedge clk);
    la = ta; lb = tb_; lcin = tc; lsub = 1'b0; lstart = 1'b1;
    @(negedge clk);
    lstart = 1'b0;
    n = 0;
    while (!ldone && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 32'd1);
    chk({tag, " sum"}, {28'd0, lsum}, {28'd0, es});
    chk({tag, " cout"}, {31'd0, lcout}, {31'd0, ec});
    chk({tag, " ovf"}, {31'd0, lovf}, 32'd0);
  endtask

  initial begin
    int n, t1;
    logic saw;
    logic [15:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lstart = 1'b0; la = '0; lb = '0; lcin = 1'b0; lsub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst sum",  {16'd0, sum},  32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    chk("rst ovf",  {31'd0, ovf},  32'd0);
    rst = 1'b0;

    op16("add",    16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});
    op16("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
    op16("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
    op16("sub",    16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    op16("borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, '{16'h000E, 1'b1, 1'b0});
    op16("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});

    // start pulsed mid-run with different operands must be ignored
    @(negedge clk);
    a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0; start = 1'b1;
    q.push_back('{16'h0303, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0; n = 0;
    @(negedge clk);
    n++;
    a = 16'hAAAA; b = 16'h1111; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    wait_done(n);
    chk("ignore latency", n, 32'd4);
    pop_cmp("ignore");

    // start held through DONE: back-to-back with no idle cycle
    @(negedge clk);
    a = 16'h1000; b = 16'h2000; cin = 1'b1; sub = 1'b0; start = 1'b1;
    q.push_back('{16'h3001, 1'b0, 1'b0});
    @(negedge clk);
    a = 16'h0003; b = 16'h0009; cin = 1'b0; sub = 1'b1;
    q.push_back('{16'hFFFA, 1'b0, 1'b0});
    n = 0;
    wait_done(n);
    t1 = n;
    chk("b2b first latency", n, 32'd4);
    chk("b2b done busy", {31'd0, busy}, 32'd0);
    pop_cmp("b2b first");
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("b2b restart busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b spacing", n - t1, 32'd5);
    pop_cmp("b2b second");

    // reset mid-operation aborts with no done
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort sum",  {16'd0, sum},  32'd0);
    chk("abort cout", {31'd0, cout}, 32'd0);
    chk("abort ovf",  {31'd0, ovf},  32'd0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("abort no done", {31'd0, saw}, 32'd0);
    op16("post rst", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, '{16'h1001, 1'b0, 1'b0});

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      op16("rand", ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    op4("legacy0", 4'b0101, 4'b1110, 1'b1, 4'b0100, 1'b1);
    op4("legacy1", 4'b1101, 4'b1010, 1'b1, 4'b1000, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/adder_serial_nbit.md
Name: adder_serial_nbit

Overview:
- Parametrised, multi-cycle digit-serial adder/subtractor; next generation of the team's fixed 4-bit combinational ripple adder.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a start/busy/done handshake.
- Adds subtract mode and signed-overflow detection.
- Used where a wide adder must fit a small area and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT and ≥ DIGIT.
- DIGIT, 4, bits processed per clock cycle; NDIG = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when accepted (IDLE or DONE).
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- cin  in  1  carry-in (add) / borrow-in (sub), captured on accepted start.
- sub  in  1  0: a+b+cin; 1: a-b-cin, captured on accepted start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when sum/cout/ovf are updated.
- sum  out  WIDTH  result, held until next completion.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow of the result.

Behaviour:
- Reset (rst=1 at edge): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; digit counter, carry and operand registers cleared. Reset wins over every other input, including mid-operation; an aborted operation produces no done.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN.
  - RUN: after NDIG digit cycles → DONE.
  - DONE: start=1 → RUN; otherwise → IDLE.
- Accept (edge with start=1 in IDLE or DONE):
  - Latch a.
  - Latch b, or ~b when sub=1.
  - Initial carry = cin when sub=0, ~cin when sub=1.
  - Clear digit index; busy=1 from the next cycle.
- RUN: each edge adds digit k of A, digit k of B' and the carry register. It writes the DIGIT-bit result into partial-sum digit k, updates carry, and increments k. start is ignored in RUN.
- Completion (edge processing digit NDIG-1):
  - Enter DONE; sum ← full partial result; cout ← final carry.
  - ovf ← (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
  - busy=0, done=1 for exactly that one cycle.
- Latency: start accepted at edge 0 → done high in the cycle after edge NDIG. Back-to-back: start held high in DONE restarts with no idle cycle, giving a throughput of one op per NDIG+1 cycles.
- sum, cout and ovf change only at completion or reset. Operand inputs may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH; the carry register is 1 bit; the digit index is $clog2(NDIG) bits wide, with a minimum of 1.
- NDIG=1 is legal: RUN lasts one cycle, and results are bit-identical to the legacy 4-bit adder when WIDTH=DIGIT=4, sub=0.

Decomposition:
- Shared package adder_pkg:
  - state enum (IDLE, RUN, DONE);
  - localparam helper computing NDIG and counter width;
  - elaboration check that WIDTH % DIGIT == 0.
- One natural sub-module: adder_digit, a combinational DIGIT-bit ripple adder (a, b, cin → s, cout) instantiated once inside the datapath. The FSM, counter and registers stay in adder_serial_nbit.

Test Plan (WIDTH=16, DIGIT=4 unless noted; "cycle n" = n edges after the edge accepting start):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0 → busy cycles 1–4, done high in the cycle after edge 4; sum=0x5555, cout=0, ovf=0.
- Wrap/carry: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. Borrow-in: a=0x0010, b=0x0001, cin=1, sub=1 → sum=0x000E, cout=1.
- Handshake:
  - Pulse start in RUN with new operands → ignored; the first op's result is unchanged.
  - Hold start high through DONE → second op starts immediately; two done pulses exactly 5 cycles apart.
- Reset mid-run: assert rst at cycle 2 → next cycle all outputs 0, state IDLE, no done. A fresh op afterwards completes correctly.
- Legacy regression (WIDTH=4, DIGIT=4): a=0101, b=1110, cin=1 → sum=0100, cout=1. Also a=1101, b=1010, cin=1 → sum=1000, cout=1; done one cycle after acceptance edge+1.
